// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MemoryUnit port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnCpu,
        OwnLdr
    } owner_e;

    localparam logic MemSelRom = 1'b0;
    localparam logic MemSelRam = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin select: on a tie the requester that did not own the port last wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic       req_cpu,
    input  logic       req_ldr,
    input  logic [1:0] last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = OwnNone;
        if (req_cpu && req_ldr) begin
            grant = (last_owner == OwnCpu) ? OwnLdr : OwnCpu;
        end else if (req_cpu) begin
            grant = OwnCpu;
        end else if (req_ldr) begin
            grant = OwnLdr;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port MemoryUnit between the MIPS core and the loader/debug port.
// Each access is an ISSUE cycle followed by a RESP cycle; the loader may lock bursts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_sel,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  cpu_stall,
    input  logic                  ldr_req,
    input  logic                  ldr_lock,
    input  logic                  ldr_we,
    input  logic                  ldr_sel,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX - 1);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_owner_q, last_owner_d;
    logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  sel_q, sel_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0] rr_last;
    logic [1:0] rr_grant;
    owner_e     pick;
    owner_e     grant;
    logic       grant_en;
    logic       lock_regrant;
    logic       cpu_rom_write;

    // In RESP the current owner becomes last_owner this cycle, so arbitrate against it.
    assign rr_last = (state_q == StResp) ? owner_q : last_owner_q;

    mem_arb_rr_pick u_rr_pick (
        .req_cpu    (cpu_req),
        .req_ldr    (ldr_req),
        .last_owner (rr_last),
        .grant      (rr_grant)
    );

    assign pick = owner_e'(rr_grant);

    // The burst cap only matters while the CPU is waiting.
    assign lock_regrant = (state_q == StResp) && (owner_q == OwnLdr) && ldr_lock && ldr_req &&
                          ((burst_cnt_q < CntMax) || !cpu_req);

    assign cpu_rom_write = cpu_we && (cpu_sel == MemSelRom);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        sel_d        = sel_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        grant        = OwnNone;
        grant_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick != OwnNone) begin
                    grant       = pick;
                    grant_en    = 1'b1;
                    state_d     = StIssue;
                    burst_cnt_d = '0;
                end
            end
            StIssue: begin
                state_d = StResp;
                rdata_d = mem_q;
            end
            StResp: begin
                last_owner_d = owner_q;
                if (lock_regrant) begin
                    grant    = OwnLdr;
                    grant_en = 1'b1;
                    state_d  = StIssue;
                    if (burst_cnt_q < CntMax) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (pick != OwnNone) begin
                    grant       = pick;
                    grant_en    = 1'b1;
                    state_d     = StIssue;
                    burst_cnt_d = '0;
                end else begin
                    state_d     = StIdle;
                    owner_d     = OwnNone;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase

        if (grant_en) begin
            owner_d = grant;
            if (grant == OwnCpu) begin
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                sel_d   = cpu_sel;
                we_d    = cpu_we && !cpu_rom_write;
                err_d   = cpu_rom_write;
            end else begin
                addr_d  = ldr_addr;
                wdata_d = ldr_wdata;
                sel_d   = ldr_sel;
                we_d    = ldr_we;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            last_owner_q <= OwnLdr;
            burst_cnt_q  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            sel_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // The memory pins carry the captured request only during ISSUE and are zero otherwise.
    assign mem_addr  = (state_q == StIssue) ? addr_q : '0;
    assign mem_wdata = (state_q == StIssue) ? wdata_q : '0;
    assign mem_sel   = (state_q == StIssue) && sel_q;
    assign mem_we    = (state_q == StIssue) && we_q;

    assign cpu_ack   = (state_q == StResp) && (owner_q == OwnCpu);
    assign ldr_ack   = (state_q == StResp) && (owner_q == OwnLdr);
    assign cpu_err   = cpu_ack && err_q;
    assign cpu_stall = cpu_req && !cpu_ack;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus lock-burst and
// mid-access reset sequences, against a small behavioural memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_sel;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_err, cpu_stall;
    logic        ldr_req, ldr_lock, ldr_we, ldr_sel;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_ack;
    logic [31:0] mem_addr, mem_wdata, mem_q, rdata;
    logic        mem_we, mem_sel;

    int n_vec;
    int n_miss;

    mem_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .LOCK_MAX   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_sel   (cpu_sel),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .ldr_req   (ldr_req),
        .ldr_lock  (ldr_lock),
        .ldr_we    (ldr_we),
        .ldr_sel   (ldr_sel),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_q     (mem_q),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: written words override a fixed default pattern.
    logic [63:0] wr_valid;
    logic [31:0] wr_data [0:63];
    logic [5:0]  midx;
    assign midx = mem_addr[7:2];

    function automatic logic [31:0] dflt(input logic [5:0] i);
        return (i == 6'd4) ? 32'h2010_FFFF : (32'hA000_0000 | {26'd0, i});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            wr_valid <= '0;
        end else if (mem_we) begin
            wr_valid[midx] <= 1'b1;
            wr_data[midx]  <= mem_wdata;
        end
    end

    always_comb begin
        mem_q = dflt(midx);
        if (wr_valid[midx]) mem_q = wr_data[midx];
    end

    typedef struct {
        logic        rst;
        logic [2:0]  c;     // {req, we, sel}
        logic [31:0] ca, cw;
        logic [3:0]  l;     // {req, lock, we, sel}
        logic [31:0] la, lw;
        logic [5:0]  e;     // {cpu_ack, cpu_err, cpu_stall, ldr_ack, mem_we, mem_sel}
        logic [31:0] ema, emw;
        logic        chk;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [2:0] c, input logic [31:0] ca,
                                input logic [31:0] cw, input logic [3:0] l,
                                input logic [31:0] la, input logic [31:0] lw,
                                input logic [5:0] e, input logic [31:0] ema,
                                input logic [31:0] emw, input logic chk,
                                input logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.c = c; v.ca = ca; v.cw = cw; v.l = l; v.la = la; v.lw = lw;
        v.e = e; v.ema = ema; v.emw = emw; v.chk = chk; v.erd = erd;
        return v;
    endfunction

    function automatic logic [69:0] outs();
        return {cpu_ack, cpu_err, cpu_stall, ldr_ack, mem_we, mem_sel, mem_addr, mem_wdata};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int c, n_l, n_c, cpu_pos, last_ack_c, nacks, stall_bad;
        n_vec = 0; n_miss = 0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_sel = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_lock = 0; ldr_we = 0; ldr_sel = 0; ldr_addr = 0; ldr_wdata = 0;

        // CPU ROM read of 0x10
        tbl.push_back(mk(0, 3'b100, 32'h10, 0, 4'b0000, 0, 0, 6'b001000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b100, 32'h10, 0, 4'b0000, 0, 0, 6'b001000, 32'h10, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b100000, 0, 0, 1, 32'h2010_FFFF));
        // Reset, then simultaneous requests: CPU, LDR, CPU, LDR
        tbl.push_back(mk(1, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b101, 32'h20, 0, 4'b1001, 32'h24, 0, 6'b001000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b101, 32'h20, 0, 4'b1001, 32'h24, 0, 6'b001001, 32'h20, 0, 0, 0));
        tbl.push_back(mk(0, 3'b101, 32'h28, 0, 4'b1001, 32'h24, 0, 6'b100000, 0, 0, 1,
                         32'hA000_0008));
        tbl.push_back(mk(0, 3'b101, 32'h28, 0, 4'b1001, 32'h24, 0, 6'b001001, 32'h24, 0, 0, 0));
        tbl.push_back(mk(0, 3'b101, 32'h28, 0, 4'b1001, 32'h2C, 0, 6'b001100, 0, 0, 1,
                         32'hA000_0009));
        tbl.push_back(mk(0, 3'b101, 32'h28, 0, 4'b1001, 32'h2C, 0, 6'b001001, 32'h28, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b1001, 32'h2C, 0, 6'b100000, 0, 0, 1, 32'hA000_000A));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b1001, 32'h2C, 0, 6'b000001, 32'h2C, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b000100, 0, 0, 1, 32'hA000_000B));
        // CPU ROM write suppressed with err; loader ROM write permitted
        tbl.push_back(mk(0, 3'b110, 32'h4, 32'hDEAD_BEEF, 4'b0000, 0, 0, 6'b001000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b110, 32'h4, 32'hDEAD_BEEF, 4'b0000, 0, 0, 6'b001000, 32'h4,
                         32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b110000, 0, 0, 1, 32'hA000_0001));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b1010, 32'h4, 32'hDEAD_BEEF, 6'b000000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b1010, 32'h4, 32'hDEAD_BEEF, 6'b000010, 32'h4,
                         32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b000100, 0, 0, 1, 32'hA000_0001));
        // CPU reads back the loader's write
        tbl.push_back(mk(0, 3'b100, 32'h4, 0, 4'b0000, 0, 0, 6'b001000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b100, 32'h4, 0, 4'b0000, 0, 0, 6'b001000, 32'h4, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b100000, 0, 0, 1, 32'hDEAD_BEEF));
        // CPU RAM write is permitted
        tbl.push_back(mk(0, 3'b111, 32'h30, 32'h1234_5678, 4'b0000, 0, 0, 6'b001000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 32'h30, 32'h1234_5678, 4'b0000, 0, 0, 6'b001011, 32'h30,
                         32'h1234_5678, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b100000, 0, 0, 1, 32'hA000_000C));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(0, 3'b000, 0, 0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 0));
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", outs(), '0);
        check("reset_rdata", {38'd0, rdata}, '0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            reset    = tbl[i].rst;
            cpu_req  = tbl[i].c[2]; cpu_we = tbl[i].c[1]; cpu_sel = tbl[i].c[0];
            cpu_addr = tbl[i].ca;   cpu_wdata = tbl[i].cw;
            ldr_req  = tbl[i].l[3]; ldr_lock = tbl[i].l[2];
            ldr_we   = tbl[i].l[1]; ldr_sel = tbl[i].l[0];
            ldr_addr = tbl[i].la;   ldr_wdata = tbl[i].lw;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), {tbl[i].e, tbl[i].ema, tbl[i].emw});
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), {38'd0, rdata},
                                  {38'd0, tbl[i].erd});
        end

        // Locked loader burst of 20 RAM writes while the CPU waits on one read
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_sel = 1; cpu_addr = 32'h40; cpu_wdata = 0;
        ldr_req = 1; ldr_lock = 1; ldr_we = 1; ldr_sel = 1; ldr_addr = 32'h100; ldr_wdata = 0;
        c = 0; n_l = 0; n_c = 0; cpu_pos = -1; last_ack_c = 0; nacks = 0; stall_bad = 0;
        while (nacks < 21 && c < 200) begin
            @(negedge clk);
            if (cpu_stall !== (cpu_req && !cpu_ack)) stall_bad++;
            if (ldr_ack) begin
                n_l++; nacks++; last_ack_c = c;
                if (n_l == 20) begin
                    ldr_req = 0; ldr_lock = 0;
                end else begin
                    ldr_addr = 32'h100 + 32'(4 * n_l); ldr_wdata = 32'(n_l);
                end
            end
            if (cpu_ack) begin
                n_c++; cpu_pos = nacks; nacks++; last_ack_c = c; cpu_req = 0;
            end
            @(posedge clk); #1;
            c++;
        end
        check("lock_no_timeout", {69'd0, c < 200}, 70'd1);
        check("lock_ldr_acks", 70'(n_l), 70'd20);
        check("lock_cpu_acks", 70'(n_c), 70'd1);
        check("lock_cpu_position", 70'(cpu_pos), 70'd16);
        check("lock_last_ack_cycle", 70'(last_ack_c), 70'd42);
        check("lock_stall", 70'(stall_bad), 70'd0);

        // Reset during ISSUE of a CPU RAM write
        cpu_req = 1; cpu_we = 1; cpu_sel = 1; cpu_addr = 32'h50; cpu_wdata = 32'h55;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_issue", {cpu_ack, mem_we, mem_addr}, {1'b0, 1'b1, 32'h50});
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        ldr_req = 1; ldr_lock = 0; ldr_we = 0; ldr_sel = 1; ldr_addr = 32'h60;
        @(negedge clk);
        check("rst_after", {cpu_ack, ldr_ack, mem_we, mem_addr}, '0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_regrant_cpu", {mem_we, mem_addr}, {1'b1, 32'h50});
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_cpu_ack", {cpu_ack, cpu_err, ldr_ack}, 70'b100);
        cpu_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ldr_ack", {cpu_ack, ldr_ack, rdata}, {1'b0, 1'b1, 32'hA000_0018});
        ldr_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("final_idle", outs(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
